// File: rtl/gate_vec_pkg.sv
// Shared definitions for the two-input gate-vector generator/decoder pair.
// Code bits: [0] AND, [1] OR, [2] NOT a, [3] XOR, [4] XNOR, [5] NAND, [6] NOR.
package gate_vec_pkg;

  localparam int GV_W = 7;

  localparam logic [GV_W-1:0] GV_CODE_00 = 7'h74;
  localparam logic [GV_W-1:0] GV_CODE_01 = 7'h2E;
  localparam logic [GV_W-1:0] GV_CODE_10 = 7'h2A;
  localparam logic [GV_W-1:0] GV_CODE_11 = 7'h13;

  typedef struct packed {
    logic a;
    logic b;
    logic err;
  } gv_entry_t;

  // Illegal codes decode to a=b=0 with err set.
  function automatic gv_entry_t gv_decode(input logic [GV_W-1:0] vec);
    gv_entry_t e;
    e = '{a: 1'b0, b: 1'b0, err: 1'b0};
    case (vec)
      GV_CODE_00: e = '{a: 1'b0, b: 1'b0, err: 1'b0};
      GV_CODE_01: e = '{a: 1'b0, b: 1'b1, err: 1'b0};
      GV_CODE_10: e = '{a: 1'b1, b: 1'b0, err: 1'b0};
      GV_CODE_11: e = '{a: 1'b1, b: 1'b1, err: 1'b0};
      default:    e = '{a: 1'b0, b: 1'b0, err: 1'b1};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/gate_vec_fifo2.sv
// Two-entry synchronous FIFO; slot0 is always the head, so out_data is a flop.
// in_ready depends only on the registered occupancy.
module gate_vec_fifo2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   occ;
  logic [W-1:0] slot0, slot1;
  logic         push, pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = slot0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            slot0 <= in_data;
            occ   <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= in_data;
          end else if (push) begin
            slot1 <= in_data;
            occ   <= 2'd2;
          end else if (pop) begin
            // Empty head reads as zero rather than a stale entry.
            slot0 <= '0;
            occ   <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0 <= slot1;
            slot1 <= '0;
            occ   <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/gate_vec_decoder.sv
// Gate-vector receiver: validates 7-bit words, recovers (a, b), buffers two
// results and keeps saturating good/bad counters plus a sticky error flag.
module gate_vec_decoder
  import gate_vec_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter bit DROP_INVALID = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [GV_W-1:0]  vec_in,
  input  logic             vec_valid_in,
  output logic             vec_ready_out,
  output logic             a_out,
  output logic             b_out,
  output logic             err_out,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  input  logic             clear_in,
  output logic [CNT_W-1:0] good_cnt_out,
  output logic [CNT_W-1:0] bad_cnt_out,
  output logic             sticky_err_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  gv_entry_t dec, head;
  logic      rdy_en, fifo_in_valid, fifo_in_ready, accept;

  assign dec = gv_decode(vec_in);

  // rdy_en keeps ready low through reset and for the release edge itself.
  assign vec_ready_out = rdy_en & fifo_in_ready;
  assign accept        = vec_valid_in & vec_ready_out;
  assign fifo_in_valid = vec_valid_in & rdy_en & (!dec.err || !DROP_INVALID);

  gate_vec_fifo2 #(.W($bits(gv_entry_t))) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .in_data   (dec),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .out_data  (head),
    .out_valid (out_valid_out),
    .out_ready (out_ready_in)
  );

  assign a_out   = head.a;
  assign b_out   = head.b;
  assign err_out = head.err;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rdy_en         <= 1'b0;
      good_cnt_out   <= '0;
      bad_cnt_out    <= '0;
      sticky_err_out <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (clear_in) begin
        good_cnt_out   <= '0;
        bad_cnt_out    <= '0;
        sticky_err_out <= 1'b0;
      end else if (accept) begin
        if (dec.err) begin
          sticky_err_out <= 1'b1;
          if (bad_cnt_out != CNT_MAX) bad_cnt_out <= bad_cnt_out + CNT_ONE;
        end else if (good_cnt_out != CNT_MAX) begin
          good_cnt_out <= good_cnt_out + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_vec_decoder.sv
// Scoreboard bench: dut0 (CNT_W=8, forward illegal) and dut1 (CNT_W=2, drop illegal).
module tb_gate_vec_decoder;
  import gate_vec_pkg::*;

  typedef struct {
    logic a;
    logic b;
    logic err;
    int   acc;
    bit   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [6:0] d0_vec, d1_vec;
  logic       d0_valid, d1_valid, d0_ready, d1_ready;
  logic       d0_a, d0_b, d0_e, d1_a, d1_b, d1_e;
  logic       d0_ovld, d1_ovld, d0_ordy, d1_ordy, d0_clr, d1_clr;
  logic [7:0] d0_good, d0_bad;
  logic [1:0] d1_good, d1_bad;
  logic       d0_sticky, d1_sticky;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_vec_decoder #(.CNT_W(8), .DROP_INVALID(1'b0)) u_dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .vec_in(d0_vec), .vec_valid_in(d0_valid),
    .vec_ready_out(d0_ready), .a_out(d0_a), .b_out(d0_b), .err_out(d0_e),
    .out_valid_out(d0_ovld), .out_ready_in(d0_ordy), .clear_in(d0_clr),
    .good_cnt_out(d0_good), .bad_cnt_out(d0_bad), .sticky_err_out(d0_sticky)
  );

  gate_vec_decoder #(.CNT_W(2), .DROP_INVALID(1'b1)) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .vec_in(d1_vec), .vec_valid_in(d1_valid),
    .vec_ready_out(d1_ready), .a_out(d1_a), .b_out(d1_b), .err_out(d1_e),
    .out_valid_out(d1_ovld), .out_ready_in(d1_ordy), .clear_in(d1_clr),
    .good_cnt_out(d1_good), .bad_cnt_out(d1_bad), .sticky_err_out(d1_sticky)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int d, input logic [6:0] v, input logic ea,
                      input logic eb, input logic ee, input bit lat);
    exp_t e;
    bit   done = 0;
    e = '{a: ea, b: eb, err: ee, acc: 0, lat: lat};
    if (d == 0) begin d0_vec = v; d0_valid = 1'b1; end
    else        begin d1_vec = v; d1_valid = 1'b1; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((d == 0) ? d0_ready : d1_ready) begin
        e.acc = cyc;
        if (d == 0) q0.push_back(e);
        else if (!ee) q1.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (d == 0) d0_valid = 1'b0;
    else        d1_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: dut%0d word %h never accepted", d, v);
    end
  endtask

  // Monitors: compare the head whenever valid; pop when the entry is taken.
  always @(negedge clk) begin
    if (d0_ovld) begin
      if (q0.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL mon0_unexpected: got {a,b,err}=%b with empty scoreboard", {d0_a, d0_b, d0_e});
      end else begin
        chk("mon0_data", {d0_a, d0_b, d0_e}, {q0[0].a, q0[0].b, q0[0].err});
        if (q0[0].lat) begin
          chk("mon0_latency", cyc, q0[0].acc + 1);
          q0[0].lat = 0;
        end
        if (d0_ordy) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (d1_ovld) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL mon1_unexpected: got {a,b,err}=%b with empty scoreboard", {d1_a, d1_b, d1_e});
      end else begin
        chk("mon1_data", {d1_a, d1_b, d1_e}, {q1[0].a, q1[0].b, q1[0].err});
        if (q1[0].lat) begin
          chk("mon1_latency", cyc, q1[0].acc + 1);
          q1[0].lat = 0;
        end
        if (d1_ordy) void'(q1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    d0_vec = '0; d0_valid = 1'b0; d0_ordy = 1'b1; d0_clr = 1'b0;
    d1_vec = '0; d1_valid = 1'b0; d1_ordy = 1'b1; d1_clr = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("rst_ovld", d0_ovld, 0);
    chk("rst_abe", {d0_a, d0_b, d0_e}, 0);
    chk("rst_ready", d0_ready, 0);
    chk("rst_cnts", {d0_good, d0_bad, d0_sticky}, 0);
    chk("rst_ready1", d1_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_release_edge", d0_ready, 0);
    @(negedge clk);
    chk("ready_after_release", d0_ready, 1);

    // Four legal codes back-to-back, one-cycle latency each
    step();
    send(0, 7'h74, 0, 0, 0, 1);
    send(0, 7'h2E, 0, 1, 0, 1);
    send(0, 7'h2A, 1, 0, 0, 1);
    send(0, 7'h13, 1, 1, 0, 1);
    @(negedge clk);
    chk("good_after_4", d0_good, 4);
    chk("bad_after_4", d0_bad, 0);
    chk("sticky_after_4", d0_sticky, 0);

    // Illegal word forwarded with err
    step();
    send(0, 7'h00, 0, 0, 1, 1);
    @(negedge clk);
    chk("bad_after_illegal", d0_bad, 1);
    chk("sticky_after_illegal", d0_sticky, 1);
    chk("good_hold", d0_good, 4);

    // Back-pressure: two absorbed, third held, head stable while stalled
    step();
    d0_ordy = 1'b0;
    send(0, 7'h74, 0, 0, 0, 0);
    send(0, 7'h13, 1, 1, 0, 0);
    @(negedge clk);
    chk("ready_full", d0_ready, 0);
    d0_vec = 7'h2E;
    d0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_stalled", d0_ready, 0);
    end
    chk("good_stalled", d0_good, 6);
    step();
    d0_ordy = 1'b1;
    send(0, 7'h2E, 0, 1, 0, 0);
    @(negedge clk);
    chk("good_after_bp", d0_good, 7);

    // Clear wins over an illegal accept in the same cycle
    step();
    d0_clr = 1'b1;
    send(0, 7'h7F, 0, 0, 1, 0);
    d0_clr = 1'b0;
    @(negedge clk);
    chk("clr_good", d0_good, 0);
    chk("clr_bad", d0_bad, 0);
    chk("clr_sticky", d0_sticky, 0);

    // dut1: saturation at 3
    step();
    send(1, 7'h74, 0, 0, 0, 1);
    send(1, 7'h2E, 0, 1, 0, 1);
    send(1, 7'h2A, 1, 0, 0, 1);
    send(1, 7'h13, 1, 1, 0, 1);
    send(1, 7'h74, 0, 0, 0, 1);
    @(negedge clk);
    chk("sat_good", d1_good, 3);

    // dut1: illegal word dropped but counted
    step();
    send(1, 7'h00, 0, 0, 1, 0);
    @(negedge clk);
    chk("drop_ovld", d1_ovld, 0);
    chk("drop_bad", d1_bad, 1);
    chk("drop_sticky", d1_sticky, 1);
    step();
    d1_clr = 1'b1;
    send(1, 7'h55, 0, 0, 1, 0);
    d1_clr = 1'b0;
    @(negedge clk);
    chk("clr1_cnts", {d1_good, d1_bad}, 0);
    chk("clr1_sticky", d1_sticky, 0);

    // Reset with two entries buffered
    step();
    d0_ordy = 1'b0;
    send(0, 7'h2A, 1, 0, 0, 0);
    send(0, 7'h13, 1, 1, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    @(negedge clk);
    chk("rst2_ovld", d0_ovld, 0);
    chk("rst2_abe", {d0_a, d0_b, d0_e}, 0);
    chk("rst2_ready", d0_ready, 0);
    chk("rst2_cnts", {d0_good, d0_bad, d0_sticky}, 0);
    step();
    rst_n = 1'b1;
    d0_ordy = 1'b1;
    @(negedge clk);
    chk("rst2_ready_edge", d0_ready, 0);
    @(negedge clk);
    chk("rst2_ready_after", d0_ready, 1);

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gate_vec_decoder.md
# gate_vec_decoder

Receive-side counterpart of the two-input gate-vector generator. Accepts 7-bit gate-output words over a valid/ready handshake, validates each against the four legal codes, recovers the (a, b) input pair that produced it, and forwards the result through a 2-entry output buffer. Maintains saturating good/bad word counters and a sticky error flag for status readout.

## Interface
- `CNT_W`, 8: width of the good and bad word counters.
- `DROP_INVALID`, 0: if 1, illegal words are consumed and counted but not forwarded.

- `clk_in` input 1: sole clock, rising edge.
- `rst_n_in` input 1: synchronous, active-low reset.
- `vec_in` input 7: gate vector; bit0 AND, bit1 OR, bit2 NOT a, bit3 XOR, bit4 XNOR, bit5 NAND, bit6 NOR.
- `vec_valid_in` input 1: `vec_in` is valid.
- `vec_ready_out` output 1: decoder can accept a word.
- `a_out`, `b_out` output 1 each: recovered inputs; both 0 when `err_out`=1.
- `err_out` output 1: forwarded word was illegal.
- `out_valid_out` output 1: head buffer entry is valid.
- `out_ready_in` input 1: downstream accepts the head entry.
- `clear_in` input 1: synchronous clear of counters and sticky flag.
- `good_cnt_out` output CNT_W: legal words accepted.
- `bad_cnt_out` output CNT_W: illegal words accepted.
- `sticky_err_out` output 1: set on any illegal word, held until cleared.

## Operation
- Legal codes map to (a, b) as follows:
  - 7'h74 → (0,0)
  - 7'h2E → (0,1)
  - 7'h2A → (1,0)
  - 7'h13 → (1,1)
- Every other code is illegal.
- Accept: `vec_valid_in & vec_ready_out` on a rising edge. A word that is not accepted has no effect.
- Decoding is combinational on `vec_in`. The decoded entry {a, b, err} is pushed into a 2-entry FIFO on accept.
- With DROP_INVALID=1, an illegal word is still accepted and counted, but it is not pushed.
- `vec_ready_out` = FIFO not full. It depends only on registered occupancy, with no combinational path from `out_ready_in`.
- Pop: `out_valid_out & out_ready_in`. `out_valid_out` = FIFO not empty. Outputs show the head entry.
- Output stability: while `out_valid_out`=1 and `out_ready_in`=0, the head entry is held unchanged.
- Simultaneous push and pop with occupancy 1: occupancy stays 1, and the new word becomes the head on the next cycle.
- Simultaneous push and pop at occupancy 2 cannot happen, because `vec_ready_out`=0 when full.
- Counters:
  - Increment on accept: `good_cnt_out` for legal words, `bad_cnt_out` for illegal words.
  - Saturate at 2^CNT_W−1, with no wrap.
- Sticky flag: `sticky_err_out` is set on the accept of an illegal word.
- Clear: `clear_in`=1 zeroes both counters and `sticky_err_out`. It has priority over increment and set in the same cycle. FIFO contents are unaffected.
- Reset (`rst_n_in`=0 at an edge):
  - FIFO emptied; `out_valid_out`=0, `a_out`=`b_out`=`err_out`=0.
  - Counters 0, `sticky_err_out`=0, `vec_ready_out`=0.
  - Any in-flight word is discarded.
  - `vec_ready_out` rises on the first edge after reset is released.

## Timing
- Latency: a word accepted at edge N is visible on `out_valid_out`/`a_out`/`b_out`/`err_out` after edge N (cycle N+1).
- Throughput: 1 word/cycle when `out_ready_in` is held high.
- Back-pressure: two words can be absorbed with `out_ready_in`=0. `vec_ready_out` falls in the cycle after the second accept.
- Status latency: counters and sticky flag update in the cycle after the accept edge.
- All outputs are registered except `vec_ready_out`, which is a decode of the registered occupancy.

## Structure
- Package `gate_vec_pkg`:
  - Code constants `GV_CODE_00`, `GV_CODE_01`, `GV_CODE_10`, `GV_CODE_11`.
  - Typedef of the decoded entry {a, b, err}.
  - Shared with the generator side and the bench.
- Sub-module `gate_vec_fifo2`: 2-entry synchronous FIFO with valid/ready on both sides and registered occupancy.
- The decode and counter logic live in the top level.

## Test plan
- Reset released, send 7'h74, 7'h2E, 7'h2A, 7'h13 back-to-back with `out_ready_in`=1 → outputs (0,0), (0,1), (1,0), (1,1) on consecutive cycles, each one cycle after accept; `err_out`=0, `good_cnt_out`=4.
- Send 7'h00 with DROP_INVALID=0 → entry with `err_out`=1, a=b=0; `bad_cnt_out`=1; `sticky_err_out`=1. Repeat with DROP_INVALID=1 → no `out_valid_out`, `bad_cnt_out`=1.
- Hold `out_ready_in`=0 and offer 3 words → first two accepted, `vec_ready_out`=0, third word held by the source; release `out_ready_in` → all three emerge in order with the head stable while stalled.
- CNT_W=2, send 5 legal words → `good_cnt_out` saturates at 3. Assert `clear_in` together with an illegal accept → counters 0 and `sticky_err_out`=0 the next cycle.
- Assert `rst_n_in`=0 with 2 entries buffered → next cycle `out_valid_out`=0, all outputs 0, `vec_ready_out`=0; first cycle after release `vec_ready_out`=1.
